// File: rtl/csa_resolve_seq.sv
// ---------------------------------------------------------------------------
// csa_resolve_seq
//
// Sequential carry-propagate resolver for the output of the 15:3 compressor
// tree. It turns a redundant (sum, carry) vector pair plus a carry-in into
// the binary value sum + carry + cin. The block resolves CHUNK bits per
// clock, starting with the least-significant chunk, and keeps the carry
// between chunks in a register.
//
// Parameters
//   WIDTH : operand/result width in bits. Must be a multiple of CHUNK.
//   CHUNK : bits resolved per clock. CHUNK == WIDTH gives single-chunk runs.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous, active-low reset
//   in_valid   sum_i/carry_i/cin_i are valid
//   in_ready   block can accept an operand pair (high only in IDLE)
//   sum_i      redundant sum vector, already aligned
//   carry_i    redundant carry vector, already aligned (bit i weight 2^i)
//   cin_i      carry into bit 0
//   out_valid  res_o/cout_o hold a finished result
//   out_ready  downstream accepts the result
//   res_o      (sum_i + carry_i + cin_i) mod 2^WIDTH
//   cout_o     carry out of bit WIDTH-1
//   busy_o     high while chunks are being resolved (RUN state)
//
// Optional build macro
//   CSA_RESOLVE_EARLY_EXIT_EN : when defined, a run ends as soon as all
//   remaining higher operand chunks are zero and the inter-chunk carry is 0.
//   The remaining result chunks are zero-filled, so the value is unchanged.
//   When undefined, every run takes exactly WIDTH/CHUNK cycles.
// ---------------------------------------------------------------------------
module csa_resolve_seq #(
  parameter int WIDTH = 256,
  parameter int CHUNK = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_i,
  input  logic [WIDTH-1:0] carry_i,
  input  logic             cin_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_o,
  output logic             cout_o,
  output logic             busy_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] carry_q;
  logic [WIDTH-1:0] res_q;
  logic [IDXW-1:0]  idx_q;
  logic             cy_q;
  logic             cout_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [CHUNK-1:0] sumChunk;
  logic [CHUNK-1:0] carryChunk;
  logic [CHUNK:0]   chunkSum;
  logic [WIDTH-1:0] res_d;
  logic             lastChunk;
  logic             runDone;
`ifdef CSA_RESOLVE_EARLY_EXIT_EN
  logic             upperZero;
  logic             earlyExit;
`endif

  // Chunk datapath: one CHUNK+1 bit add of the current operand chunks and
  // the carry register. res_d is the result register with the current chunk
  // replaced; in the early-exit build the chunks above it are also cleared
  // when the run finishes early, because res_q still holds the previous
  // operation's value there.
  always_comb begin
    sumChunk   = sum_q[idx_q*CHUNK +: CHUNK];
    carryChunk = carry_q[idx_q*CHUNK +: CHUNK];
    chunkSum   = {1'b0, sumChunk} + {1'b0, carryChunk} + {{CHUNK{1'b0}}, cy_q};
    lastChunk  = (idx_q == LAST_IDX);

    res_d = res_q;
    for (int j = 0; j < NCHUNK; j++) begin
      if (IDXW'(j) == idx_q) begin
        res_d[j*CHUNK +: CHUNK] = chunkSum[CHUNK-1:0];
      end
    end

`ifdef CSA_RESOLVE_EARLY_EXIT_EN
    upperZero = 1'b1;
    for (int j = 0; j < NCHUNK; j++) begin
      if ((IDXW'(j) > idx_q) &&
          ((sum_q[j*CHUNK +: CHUNK] | carry_q[j*CHUNK +: CHUNK]) != '0)) begin
        upperZero = 1'b0;
      end
    end
    earlyExit = upperZero && !chunkSum[CHUNK];
    if (earlyExit) begin
      for (int j = 0; j < NCHUNK; j++) begin
        if (IDXW'(j) > idx_q) begin
          res_d[j*CHUNK +: CHUNK] = '0;
        end
      end
    end
    runDone = lastChunk || earlyExit;
`else
    runDone = lastChunk;
`endif
  end

  // Control FSM with registered handshake outputs. Operands are captured
  // only on the IDLE accept; in RUN one chunk is written per clock; DONE
  // holds the result until out_ready. The carry out of the final chunk is
  // the overall carry out; on an early exit that carry is known to be 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      carry_q     <= '0;
      res_q       <= '0;
      idx_q       <= '0;
      cy_q        <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sum_q      <= sum_i;
            carry_q    <= carry_i;
            cy_q       <= cin_i;
            idx_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          res_q <= res_d;
          cy_q  <= chunkSum[CHUNK];
          if (runDone) begin
            cout_q      <= chunkSum[CHUNK];
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy_o    = busy_q;
  assign res_o     = res_q;
  assign cout_o    = cout_q;

endmodule

// File: tb/tb_csa_resolve_seq.sv
// ---------------------------------------------------------------------------
// tb_csa_resolve_seq
//
// Directed self-checking bench for csa_resolve_seq at WIDTH=64, CHUNK=16.
// Each scenario task drives its own stimulus and compares against
// hand-computed values. Inputs change on the falling edge; outputs are
// sampled on the falling edge or 1 time unit after a rising edge.
// ---------------------------------------------------------------------------
module tb_csa_resolve_seq;

  localparam int WIDTH = 64;
  localparam int CHUNK = 16;

`ifdef CSA_RESOLVE_EARLY_EXIT_EN
  localparam int LAT_SMALL = 1;
  localparam int LAT_TWO   = 2;
`else
  localparam int LAT_SMALL = 4;
  localparam int LAT_TWO   = 4;
`endif
  localparam int LAT_FULL = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum_i;
  logic [WIDTH-1:0] carry_i;
  logic             cin_i;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res_o;
  logic             cout_o;
  logic             busy_o;

  int assertCount = 0;
  int failCount   = 0;

  csa_resolve_seq #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sum_i    (sum_i),
    .carry_i  (carry_i),
    .cin_i    (cin_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res_o    (res_o),
    .cout_o   (cout_o),
    .busy_o   (busy_o)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, failures so far %0d", failCount);
    $fatal(1, "[TB] watchdog");
  end

  // Presents one operand pair for a single clock starting at a falling edge;
  // returns 1 unit after the rising edge on which it is accepted.
  task automatic sendOperand(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                             input logic ci);
    @(negedge clk);
    in_valid = 1'b1;
    sum_i    = s;
    carry_i  = c;
    cin_i    = ci;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts rising edges until out_valid is seen, bounded at 30 edges.
  task automatic waitOutValid(output int edges);
    edges = 0;
    while (!out_valid && edges < 30) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  // Completes the output handshake with out_ready high.
  task automatic consumeResult();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sum_i     = '0;
    carry_i   = '0;
    cin_i     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    assertCount++;
    if (in_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    assertCount++;
    if (out_valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    assertCount++;
    if (res_o !== 64'h0) begin
      failCount++;
      $display("[TB] FAIL reset_res: got %h expected 0", res_o);
    end
    assertCount++;
    if (cout_o !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_cout: got %b expected 0", cout_o);
    end
    assertCount++;
    if (busy_o !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_busy: got %b expected 0", busy_o);
    end
  endtask

  task automatic test_basic_add();
    int n;
    out_ready = 1'b1;
    sendOperand(64'h0000_0000_0000_1234, 64'h0000_0000_0000_0001, 1'b0);
    assertCount++;
    if (busy_o !== 1'b1 || in_ready !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL basic_run_flags: got busy=%b in_ready=%b expected busy=1 in_ready=0",
               busy_o, in_ready);
    end
    waitOutValid(n);
    assertCount++;
    if (n !== LAT_SMALL) begin
      failCount++;
      $display("[TB] FAIL basic_latency: got %0d edges expected %0d", n, LAT_SMALL);
    end
    assertCount++;
    if (res_o !== 64'h0000_0000_0000_1235 || cout_o !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL basic_result: got res=%h cout=%b expected res=0000000000001235 cout=0",
               res_o, cout_o);
    end
    assertCount++;
    if (busy_o !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL basic_busy_done: got %b expected 0", busy_o);
    end
    @(posedge clk);
    #1;
    assertCount++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL basic_return_idle: got out_valid=%b in_ready=%b expected 0/1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_full_ripple();
    int n;
    out_ready = 1'b1;
    sendOperand(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    waitOutValid(n);
    assertCount++;
    if (n !== LAT_FULL) begin
      failCount++;
      $display("[TB] FAIL ripple1_latency: got %0d expected %0d", n, LAT_FULL);
    end
    assertCount++;
    if (res_o !== 64'h0 || cout_o !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL ripple1_result: got res=%h cout=%b expected res=0 cout=1", res_o, cout_o);
    end
    consumeResult();
    sendOperand(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    waitOutValid(n);
    assertCount++;
    if (res_o !== 64'hFFFF_FFFF_FFFF_FFFF || cout_o !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL ripple2_result: got res=%h cout=%b expected res=ffffffffffffffff cout=1",
               res_o, cout_o);
    end
    consumeResult();
  endtask

  task automatic test_cin_only();
    int n;
    out_ready = 1'b1;
    sendOperand(64'h0, 64'h0, 1'b1);
    waitOutValid(n);
    assertCount++;
    if (n !== LAT_SMALL) begin
      failCount++;
      $display("[TB] FAIL cin_latency: got %0d expected %0d", n, LAT_SMALL);
    end
    assertCount++;
    if (res_o !== 64'h1 || cout_o !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL cin_result: got res=%h cout=%b expected res=1 cout=0", res_o, cout_o);
    end
    consumeResult();
  endtask

  task automatic test_backpressure();
    int n;
    logic [WIDTH-1:0] held;
    out_ready = 1'b0;
    sendOperand(64'h1111_2222_3333_4444, 64'h1000_0000_0000_0001, 1'b1);
    waitOutValid(n);
    assertCount++;
    if (n !== LAT_FULL) begin
      failCount++;
      $display("[TB] FAIL bp_latency: got %0d expected %0d", n, LAT_FULL);
    end
    assertCount++;
    if (res_o !== 64'h2111_2222_3333_4446 || cout_o !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL bp_result: got res=%h cout=%b expected res=2111222233334446 cout=0",
               res_o, cout_o);
    end
    held = res_o;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) begin
        in_valid = 1'b1;
        sum_i    = 64'hDEAD_BEEF_0000_0001;
        carry_i  = 64'h0000_0000_0000_0002;
        cin_i    = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      assertCount++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || res_o !== held || cout_o !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL bp_hold[%0d]: got out_valid=%b in_ready=%b res=%h cout=%b expected 1/0/%h/0",
                 i, out_valid, in_ready, res_o, cout_o, held);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    assertCount++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL bp_consume: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    assertCount++;
    if (busy_o !== 1'b0 || in_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL bp_no_capture: got busy=%b in_ready=%b expected 0/1", busy_o, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    int  n;
    logic sawValid;
    out_ready = 1'b1;
    sendOperand(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    assertCount++;
    if (out_valid !== 1'b0 || busy_o !== 1'b0 || in_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL midrst_flags: got out_valid=%b busy=%b in_ready=%b expected 0/0/1",
               out_valid, busy_o, in_ready);
    end
    assertCount++;
    if (res_o !== 64'h0 || cout_o !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midrst_outputs: got res=%h cout=%b expected 0/0", res_o, cout_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    sawValid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
    end
    assertCount++;
    if (sawValid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midrst_stale: got out_valid seen=%b expected 0", sawValid);
    end
    sendOperand(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0);
    waitOutValid(n);
    assertCount++;
    if (n !== LAT_FULL || res_o !== 64'h1234_5678_9ABC_DF00 || cout_o !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midrst_next_op: got lat=%0d res=%h cout=%b expected lat=%0d res=123456789abcdf00 cout=0",
               n, res_o, cout_o, LAT_FULL);
    end
    consumeResult();
  endtask

  task automatic test_early_exit();
    int n;
    out_ready = 1'b1;
    sendOperand(64'h5, 64'h3, 1'b0);
    waitOutValid(n);
    assertCount++;
    if (n !== LAT_SMALL || res_o !== 64'h8 || cout_o !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL early_small: got lat=%0d res=%h cout=%b expected lat=%0d res=8 cout=0",
               n, res_o, cout_o, LAT_SMALL);
    end
    consumeResult();
    sendOperand(64'hFFFF, 64'h1, 1'b0);
    waitOutValid(n);
    assertCount++;
    if (n !== LAT_TWO || res_o !== 64'h1_0000 || cout_o !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL early_two: got lat=%0d res=%h cout=%b expected lat=%0d res=10000 cout=0",
               n, res_o, cout_o, LAT_TWO);
    end
    consumeResult();
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_full_ripple();
    test_cin_only();
    test_backpressure();
    test_reset_mid_run();
    test_early_exit();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
